mem_rf_mrp: RTL and testbench
=============================

# mem_rf_mrp

Parametrised multi-read-port register-file memory: one synchronous write port with byte enables and NRD independent synchronous read ports, each with its own read enable and a registered output. A configurable read-during-write mode sets whether a same-cycle write to the addressed word is forwarded to the read output. An optional post-reset clear sequencer zeroes the whole array and reports `busy` until it finishes. This block replaces the fixed 64x256, two-read-address memory in the memory-inference test set and is the generic RF for lowering tests.

## Interface
- `DW`, 64, data width in bits; must be a multiple of 8.
- `AW`, 8, address width; depth is 2^AW words.
- `NRD`, 2, number of read ports (≥1).
- `BYPASS`, 1, 1 = write-first forwarding on a same-address read; 0 = read returns old data.
- `INIT_CLEAR`, 1, 1 = zero the array after reset; 0 = array contents undefined after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `we0`  in  1  write enable.
- `waddr0`  in  AW  write address.
- `din0`  in  DW  write data.
- `wmask0`  in  DW/8  byte enables; bit b covers `din0[8b+7:8b]`.
- `re`  in  NRD  per-port read enable.
- `raddr`  in  NRD*AW  packed read addresses; port i uses `[i*AW +: AW]`.
- `q`  out  NRD*DW  packed registered read data; port i uses `[i*DW +: DW]`.
- `busy`  out  1  clear sequence in progress; all accesses are ignored.

## Operation
- Reset: asserting `reset` immediately forces `q`=0 and the control state. If INIT_CLEAR=1: state CLEAR, clear pointer 0, `busy`=1. If INIT_CLEAR=0: state IDLE, `busy`=0. Array storage has no reset.
- State machine:
  - CLEAR: each cycle writes 0 to `rf[ptr]` and increments `ptr`. When `ptr`=2^AW−1, that word is written and the next state is IDLE.
  - IDLE: normal operation. There is no transition back to CLEAR except through `reset`.
- During CLEAR:
  - `we0` and `re` are ignored.
  - `q` holds 0.
- Write (IDLE, `we0`=1): for each byte b with `wmask0[b]`=1, `rf[waddr0]` byte b ← `din0` byte b. Other bytes keep their value. `we0`=1 with `wmask0`=0 is a no-op.
- Read port i (IDLE):
  - `re[i]`=1: `q_i` ← `rf[raddr_i]` at the next edge.
  - `re[i]`=0: `q_i` holds its previous value.
- Read-during-write (`re[i]`=1, `we0`=1, `raddr_i`=`waddr0`):
  - BYPASS=1: `q_i` gets `din0` bytes where the mask bit is set and the old array bytes elsewhere.
  - BYPASS=0: `q_i` gets the old word.
  - The array update happens in either mode.
- Several ports may read the same address in the same cycle; each port gets identical data.
- Addresses wrap naturally; every AW-bit value is a valid word.

## Timing
- Read latency: 1 cycle from `re`/`raddr` sampled to `q` valid.
- Write visible to a read issued in the next cycle (1-cycle write-to-read latency), regardless of BYPASS.
- Clear duration: after `reset` deasserts, `busy` stays 1 for exactly 2^AW rising edges and falls on the edge that writes the last word. The first accepted access is in the cycle after `busy` is seen as 0.
- `reset` asserted mid-clear: the pointer restarts at 0 and a full clear is redone.
- `reset` asserted mid-operation: `q` goes to 0 asynchronously. Array contents are zeroed again only if INIT_CLEAR=1.
- `busy` is a registered output, 0 or 1 at reset per INIT_CLEAR; it never glitches.

## Test plan
- Clear: AW=4, INIT_CLEAR=1. Release reset → `busy`=1 for 16 cycles. Then read addresses 0..15 on both ports → all `q`=0.
- Basic R/W: write 0x0123456789ABCDEF to addr 5 with mask 0xFF. Next cycle `re`=2'b11, raddr0=raddr1=5 → both `q`=0x0123456789ABCDEF one cycle later.
- Byte mask: addr 5 holds 0x0123456789ABCDEF. Write 0xFFFFFFFFFFFFFFFF with mask 0x0F → a later read returns 0x01234567FFFFFFFF.
- Read-during-write: addr 9 = 0xAA..AA. Same cycle write 0x55..55 (mask 0xFF) and read addr 9 → BYPASS=1 gives 0x55..55; BYPASS=0 gives 0xAA..AA. The next read returns 0x55..55 in both modes.
- Read enable hold: `q0`=0x11. Set `re[0]`=0 and change `raddr0` to a word holding 0x22 → `q0` stays 0x11 for 3 cycles. Set `re[0]`=1 → `q0`=0x22.
- Reset mid-clear: assert `reset` at clear cycle 7 and release it → `busy` high for a full 16 cycles again, `q`=0 throughout, and writes attempted while `busy` leave the array all zero.

Source files
------------

// File: rtl/mem_rf_mrp.sv
// rtl/mem_rf_mrp.sv - multi-read-port register file with byte-masked write and post-reset clear
// One masked write port, NRD registered read ports, optional write-first forwarding.
module mem_rf_mrp #(
  parameter int DW         = 64,
  parameter int AW         = 8,
  parameter int NRD        = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     din0,
  input  logic [DW/8-1:0]   wmask0,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] q,
  output logic              busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NRD*DW-1:0] q_q, q_d;

  logic [DW-1:0]     mem_q [DEPTH];

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NB-1:0]     wr_mask;
  logic [DW-1:0]     rd_word [NRD];

  function automatic logic [DW-1:0] merge_bytes(
    input logic [DW-1:0] old_word,
    input logic [DW-1:0] new_word,
    input logic [NB-1:0] mask
  );
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // State register; array storage deliberately has no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
      ptr_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (&ptr_q) state_d = S_IDLE;
    end
  end

  // Read data per port, with same-cycle write forwarded when BYPASS is set.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_word[i] = mem_q[raddr[i*AW +: AW]];
      if ((BYPASS != 0) && we0 && (raddr[i*AW +: AW] == waddr0)) begin
        rd_word[i] = merge_bytes(rd_word[i], din0, wmask0);
      end
    end
  end

  always_comb begin
    busy    = (state_q == S_CLEAR);
    wr_en   = 1'b0;
    wr_addr = waddr0;
    wr_data = din0;
    wr_mask = wmask0;
    q_d     = q_q;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      wr_data = '0;
      wr_mask = '1;
      q_d     = '0;
    end else begin
      wr_en = we0;
      for (int i = 0; i < NRD; i++) begin
        if (re[i]) q_d[i*DW +: DW] = rd_word[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= merge_bytes(mem_q[wr_addr], wr_data, wr_mask);
  end

  assign q = q_q;

endmodule

// File: tb/tb_mem_rf_mrp.sv
// tb/tb_mem_rf_mrp.sv - randomized and directed checks of mem_rf_mrp against a word-array model
module tb_mem_rf_mrp;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         we = 1'b0;
  logic [3:0]   waddr = '0;
  logic [63:0]  din = '0;
  logic [7:0]   wmask = '0;
  logic [1:0]   re = '0;
  logic [7:0]   raddr = '0;
  logic [127:0] q_b, q_n;
  logic         busy_b, busy_n;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] mem_m [16];
  logic [63:0] qb_m [2];
  logic [63:0] qn_m [2];
  int          clr_left;

  always #5 clk = ~clk;

  mem_rf_mrp #(.DW(64), .AW(4), .NRD(2), .BYPASS(1), .INIT_CLEAR(1)) dut_b (
    .clk(clk), .reset(reset), .we0(we), .waddr0(waddr), .din0(din), .wmask0(wmask),
    .re(re), .raddr(raddr), .q(q_b), .busy(busy_b)
  );

  mem_rf_mrp #(.DW(64), .AW(4), .NRD(2), .BYPASS(0), .INIT_CLEAR(1)) dut_n (
    .clk(clk), .reset(reset), .we0(we), .waddr0(waddr), .din0(din), .wmask0(wmask),
    .re(re), .raddr(raddr), .q(q_n), .busy(busy_n)
  );

  function automatic logic [63:0] apply_mask(input logic [63:0] old, input logic [63:0] d,
                                             input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy_b"}, 128'(busy_b), 128'(clr_left > 0));
    check({tag, "_busy_n"}, 128'(busy_n), 128'(clr_left > 0));
    check({tag, "_q_byp"}, q_b, {qb_m[1], qb_m[0]});
    check({tag, "_q_nob"}, q_n, {qn_m[1], qn_m[0]});
  endtask

  task automatic step(input string tag, input logic w, input logic [3:0] wa, input logic [63:0] d,
                      input logic [7:0] m, input logic [1:0] r, input logic [3:0] a0,
                      input logic [3:0] a1);
    logic [3:0]  ra [2];
    logic [63:0] old;
    we = w; waddr = wa; din = d; wmask = m; re = r; raddr = {a1, a0};
    ra[0] = a0; ra[1] = a1;
    if (clr_left > 0) begin
      mem_m[16 - clr_left] = '0;
      clr_left--;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (r[p]) begin
          old = mem_m[ra[p]];
          qn_m[p] = old;
          qb_m[p] = (w && ra[p] == wa) ? apply_mask(old, d, m) : old;
        end
      end
      if (w) mem_m[wa] = apply_mask(mem_m[wa], d, m);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    for (int p = 0; p < 2; p++) begin
      qb_m[p] = '0;
      qn_m[p] = '0;
    end
    clr_left = 16;
    check("rst_async_q_byp", q_b, '0);
    check("rst_async_q_nob", q_n, '0);
    repeat (hold) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b0;
  endtask

  initial begin
    clr_left = 16;
    qb_m[0] = '0; qb_m[1] = '0; qn_m[0] = '0; qn_m[1] = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    #2;
    do_reset(2);

    // Full clear with random access attempts that must be ignored.
    for (int i = 0; i < 16; i++)
      step("clear", 1'b1, 4'(i), {$urandom, $urandom}, 8'hFF, 2'b11, 4'(i), 4'(15 - i));
    for (int i = 0; i < 16; i++) begin
      step("clr_read", 1'b0, 4'd0, 64'd0, 8'h00, 2'b11, 4'(i), 4'(15 - i));
      check("clr_zero", q_b, '0);
    end

    step("wr5", 1'b1, 4'd5, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 4'd0, 4'd0);
    step("rd5", 1'b0, 4'd0, 64'd0, 8'h00, 2'b11, 4'd5, 4'd5);
    check("basic_rw", q_b, {2{64'h0123456789ABCDEF}});
    step("wr5m", 1'b1, 4'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'b00, 4'd0, 4'd0);
    step("rd5m", 1'b0, 4'd0, 64'd0, 8'h00, 2'b01, 4'd5, 4'd0);
    check("byte_mask", q_n[63:0], 64'h01234567FFFFFFFF);
    step("wr5z", 1'b1, 4'd5, 64'h1, 8'h00, 2'b00, 4'd0, 4'd0);
    step("rd5z", 1'b0, 4'd0, 64'd0, 8'h00, 2'b10, 4'd0, 4'd5);
    check("mask0_noop", q_b[127:64], 64'h01234567FFFFFFFF);

    step("wr9", 1'b1, 4'd9, {8{8'hAA}}, 8'hFF, 2'b00, 4'd0, 4'd0);
    step("rdw9", 1'b1, 4'd9, {8{8'h55}}, 8'hFF, 2'b01, 4'd9, 4'd0);
    check("rdw_bypass", q_b[63:0], {8{8'h55}});
    check("rdw_nobypass", q_n[63:0], {8{8'hAA}});
    step("rd9", 1'b0, 4'd0, 64'd0, 8'h00, 2'b11, 4'd9, 4'd9);
    check("rdw_after", q_n, {2{64'h5555555555555555}});

    step("wr1", 1'b1, 4'd1, 64'h11, 8'hFF, 2'b00, 4'd0, 4'd0);
    step("wr2", 1'b1, 4'd2, 64'h22, 8'hFF, 2'b00, 4'd0, 4'd0);
    step("rd1", 1'b0, 4'd0, 64'd0, 8'h00, 2'b01, 4'd1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, 4'd0, 64'd0, 8'h00, 2'b00, 4'd2, 4'd0);
      check("re_hold", q_b[63:0], 64'h11);
    end
    step("rd2", 1'b0, 4'd0, 64'd0, 8'h00, 2'b01, 4'd2, 4'd0);
    check("re_release", q_b[63:0], 64'h22);

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom),
           2'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Read a nonzero word so the asynchronous reset of q is observable.
    step("prefill", 1'b1, 4'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'b00, 4'd0, 4'd0);
    step("prerd", 1'b0, 4'd0, 64'd0, 8'h00, 2'b11, 4'd3, 4'd3);
    do_reset(1);
    for (int i = 0; i < 7; i++)
      step("clear_part", 1'b1, 4'(i), {$urandom, $urandom}, 8'hFF, 2'b11, 4'(i), 4'(i));
    do_reset(1);
    for (int i = 0; i < 16; i++)
      step("reclear", 1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom),
           2'b11, 4'(i), 4'(i));
    for (int i = 0; i < 16; i++) begin
      step("reclr_read", 1'b0, 4'd0, 64'd0, 8'h00, 2'b11, 4'(i), 4'(15 - i));
      check("reclr_zero", q_n, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
